if_prefetch: RTL and testbench

Parametrised instruction-fetch front end that replaces the fixed PC register plus IF/ID latch pair of the five-stage core. Generates sequential fetch addresses, issues them to instruction memory over a request/grant/response handshake, and buffers returned words in a DEPTH-entry prefetch FIFO. Presents {pc, inst} to the decode stage with valid/ready back-pressure and discards stale fetches on a redirect (branch/jump).

---
 rtl/if_prefetch_pkg.sv | 25 ++
 rtl/if_prefetch_sync_fifo.sv | 55 +++++
 rtl/if_prefetch.sv | 121 ++++++++++++
 tb/tb_if_prefetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared widths and constants for the instruction-fetch front end.
package if_prefetch_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned INST_ADDR_BUS = XLEN_DEF;
  localparam int unsigned INST_BUS      = XLEN_DEF;

  typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;
  typedef logic [INST_BUS-1:0]      inst_t;

  localparam inst_addr_t RESET_PC_DEF = '0;
  localparam inst_t      INST_NOP     = 32'h0000_0013;

  // What happens to a memory response arriving this cycle.
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_KEEP,
    RSP_DROP
  } rsp_kind_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_sync_fifo.sv
// Power-of-two synchronous FIFO with push/pop/flush and occupancy count.
module sync_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  input  logic                        flush,
  output logic [WIDTH-1:0]            rdata,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: sequential fetch, in-order responses, prefetch FIFO.
// Optional IF_PREFETCH_PERF_EN adds fetch/drop event counters.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_inst_o
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_drop_o
`endif
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     outs;
  logic [CW-1:0]     outs_next;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       in_use;
  logic              grant;
  logic              fifo_push;
  logic              fifo_pop;
  logic [2*XLEN-1:0] fifo_rdata;
  logic [XLEN-1:0]   pcq_head;
  rsp_kind_e         rsp_kind;

  // Buffered words plus in-flight requests never exceed DEPTH, so responses need no back-pressure.
  assign in_use     = {1'b0, fifo_count} + {1'b0, outs};
  assign mem_req_o  = ~rst & ~redirect_i & (in_use < (CW+1)'(DEPTH));
  assign mem_addr_o = fetch_pc;
  assign grant      = mem_req_o & mem_gnt_i;
  assign outs_next  = outs + CW'(grant) - CW'(mem_rvalid_i);

  always_comb begin
    rsp_kind = RSP_NONE;
    if (mem_rvalid_i) begin
      if (redirect_i || (drop != '0)) rsp_kind = RSP_DROP;
      else                            rsp_kind = RSP_KEEP;
    end
  end

  assign fifo_push = (rsp_kind == RSP_KEEP);
  assign fifo_pop  = id_valid_o & id_ready_i & ~redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i & ~XLEN'(3);
      drop     <= outs_next;
    end else begin
      if (grant)                fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_kind == RSP_DROP) drop     <= drop - CW'(1);
    end
  end

  // In-flight address queue; its occupancy is the outstanding-request count.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .wdata (fetch_pc),
    .pop   (mem_rvalid_i),
    .flush (1'b0),
    .rdata (pcq_head),
    .count (outs)
  );

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_prefetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({pcq_head, mem_rdata_i}),
    .pop   (fifo_pop),
    .flush (redirect_i),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign id_valid_o = (fifo_count != '0);
  assign id_pc_o    = id_valid_o ? fifo_rdata[2*XLEN-1:XLEN] : '0;
  assign id_inst_o  = id_valid_o ? fifo_rdata[XLEN-1:0]      : '0;

`ifdef IF_PREFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_o <= '0;
      perf_drop_o  <= '0;
    end else begin
      if (fifo_push)                perf_fetch_o <= perf_fetch_o + 32'd1;
      if (rsp_kind == RSP_DROP)     perf_drop_o  <= perf_drop_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with an in-order memory model and a stream-level reference.
module tb_if_prefetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_drop_o;
`endif

  if_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch_o),
    .perf_drop_o   (perf_drop_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t        mem_q[$];
  int          ep_q[$];
  logic [31:0] acc_q[$];
  int          gnt_cnt = 0;

  // Reference state: words the decode stage may legally see right now.
  int          epoch = 0;
  int          buffered = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_gaddr = RESET_PC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: in-order responses, rdata = ~addr, 'lat' cycles after the grant.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst) begin
      mem_q.delete();
      mem_rvalid_i = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = ~mem_q[0].addr;
      void'(mem_q.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      ep_q.delete();
      buffered  = 0;
      exp_pc    = RESET_PC;
      exp_gaddr = RESET_PC;
      epoch++;
    end else begin
      chk("req", mem_req_o, !redirect_i && (buffered + ep_q.size() < DEPTH));
      chk("id_valid", id_valid_o, buffered > 0);
      if (mem_req_o) chk("addr", mem_addr_o, exp_gaddr);
      if (id_valid_o && id_ready_i && !redirect_i) begin
        chk("id_pc", id_pc_o, exp_pc);
        chk("id_inst", id_inst_o, ~exp_pc);
        acc_q.push_back(id_pc_o);
        exp_pc = exp_pc + 32'd4;
        if (buffered > 0) buffered--;
      end
      if (mem_req_o && mem_gnt_i) begin
        ep_q.push_back(epoch);
        mem_q.push_back('{addr: mem_addr_o, due: cyc + lat});
        exp_gaddr = exp_gaddr + 32'd4;
        gnt_cnt++;
      end
      if (mem_rvalid_i) begin
        if (ep_q.size() == 0) begin
          chk("rsp_expected", 32'd1, 32'd0);
        end else begin
          if (ep_q.pop_front() == epoch && !redirect_i) buffered++;
        end
      end
      if (redirect_i) begin
        epoch++;
        buffered  = 0;
        exp_pc    = redirect_pc_i & ~32'd3;
        exp_gaddr = redirect_pc_i & ~32'd3;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_i = 1'b0;
    mem_gnt_i = 1'b0;
    id_ready_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a;
    int n;
    int g0;
    int found8;

    #1 rst = 1'b1;
    #2;
    chk("rst_req", mem_req_o, 0);
    chk("rst_valid", id_valid_o, 0);
    chk("rst_pc", id_pc_o, 0);
    chk("rst_inst", id_inst_o, 0);

    // Streaming: one instruction per cycle from RESET_PC
    do_reset();
    #1;
    chk("first_req", mem_req_o, 1);
    chk("first_addr", mem_addr_o, RESET_PC);
    lat = 1; mem_gnt_i = 1'b1; id_ready_i = 1'b1;
    acc_q.delete();
    repeat (20) step();
    a = acc_q.size();
    repeat (10) step();
    chk("throughput", acc_q.size() - a, 10);
    chk("seq0", acc_q[0], 32'h0);
    chk("seq1", acc_q[1], 32'h4);
    chk("seq2", acc_q[2], 32'h8);

    // Full: exactly DEPTH grants with decode stalled, one more per pop
    do_reset();
    lat = 1; mem_gnt_i = 1'b1; id_ready_i = 1'b0;
    g0 = gnt_cnt;
    repeat (10) step();
    #1;
    chk("full_grants", gnt_cnt - g0, 4);
    chk("full_req", mem_req_o, 0);
    id_ready_i = 1'b1;
    step();
    id_ready_i = 1'b0;
    #1;
    chk("refill_req", mem_req_o, 1);
    repeat (5) step();
    chk("refill_grants", gnt_cnt - g0, 5);

    // Redirect with three requests outstanding
    do_reset();
    lat = 4; mem_gnt_i = 1'b1; id_ready_i = 1'b1;
    acc_q.delete();
    n = 0;
    while (mem_q.size() != 3 && n < 30) begin step(); n++; end
    chk("redir_setup", mem_q.size(), 3);
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    #1;
    chk("redir_req_low", mem_req_o, 0);
    step();
    redirect_i = 1'b0;
    #1;
    chk("redir_addr", mem_addr_o, 32'h100);
    chk("redir_valid", id_valid_o, 0);
    repeat (15) step();
    chk("redir_first_pc", acc_q[0], 32'h100);
    chk("redir_second_pc", acc_q[1], 32'h104);
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_drop", perf_drop_o, 3);
`endif

    // Redirect in the same cycle as the response for 0x8
    do_reset();
    lat = 1; mem_gnt_i = 1'b1; id_ready_i = 1'b1;
    acc_q.delete();
    n = 0;
    while (!(mem_rvalid_i && mem_rdata_i == ~32'h8) && n < 30) begin step(); n++; end
    chk("rv8_seen", n < 30, 1);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step();
    redirect_i = 1'b0;
    repeat (10) step();
    found8 = 0;
    foreach (acc_q[i]) if (acc_q[i] == 32'h8) found8 = 1;
    chk("no_pc8", found8, 0);
    chk("rv8_next_pc", acc_q[1], 32'h200);

    // Grant withheld: address held stable
    do_reset();
    lat = 1; mem_gnt_i = 1'b0; id_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_req", mem_req_o, 1);
      chk("hold_addr", mem_addr_o, 32'h0);
      step();
    end
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    #1;
    chk("hold_next_addr", mem_addr_o, 32'h4);

    // Reset mid-stream with a full FIFO
    do_reset();
    lat = 1; mem_gnt_i = 1'b1; id_ready_i = 1'b0;
    repeat (10) step();
    #1;
    chk("pre_rst_valid", id_valid_o, 1);
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_fetch", perf_fetch_o, 4);
`endif
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", id_valid_o, 0);
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_pc", id_pc_o, 0);
`ifdef IF_PREFETCH_PERF_EN
    chk("mid_rst_perf_fetch", perf_fetch_o, 0);
    chk("mid_rst_perf_drop", perf_drop_o, 0);
`endif
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_req", mem_req_o, 1);
    chk("post_rst_addr", mem_addr_o, RESET_PC);
    mem_gnt_i = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
